// File: rtl/block_spi_master.sv
// SPI mode-0 master with active-high CS: sends one 16-bit {address, data} frame MSB first
// and shifts SPI_MISO in on each SCK rising edge for read-back.
module block_spi_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  address_in,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] rx_data,
    output logic        SPI_SCK,
    output logic        SPI_CS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    localparam int MAX_CNT = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      bit_reg, bit_next;
    logic [15:0]     tx_reg, tx_next;
    logic [15:0]     rx_shift_reg, rx_shift_next;
    logic [15:0]     rx_data_reg, rx_data_next;
    logic            sck_reg, sck_next;
    logic            cs_reg, cs_next;
    logic            mosi_reg, mosi_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            tx_reg       <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            sck_reg      <= 1'b0;
            cs_reg       <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            tx_reg       <= tx_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            sck_reg      <= sck_next;
            cs_reg       <= cs_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Outputs are registered and updated on the transition into each phase,
    // so SCK/CS/MOSI follow the state with no combinational glitches.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        tx_next       = tx_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        sck_next      = sck_reg;
        cs_next       = cs_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                sck_next  = 1'b0;
                cs_next   = 1'b0;
                mosi_next = 1'b0;
                if (start) begin
                    tx_next    = {address_in, data_in};
                    bit_next   = 4'd15;
                    cnt_next   = '0;
                    state_next = SETUP;
                    cs_next    = 1'b1;
                    mosi_next  = address_in[7];
                    busy_next  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next      = '0;
                    state_next    = SCK_HI;
                    sck_next      = 1'b1;
                    rx_shift_next = {rx_shift_reg[14:0], SPI_MISO};
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            SCK_HI: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = SCK_LO;
                    sck_next   = 1'b0;
                    tx_next    = {tx_reg[14:0], 1'b0};
                    mosi_next  = tx_reg[14];
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            SCK_LO: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (bit_reg == 4'd0) begin
                        state_next = GAP;
                        cs_next    = 1'b0;
                        mosi_next  = 1'b0;
                    end else begin
                        // Sampling MISO on the edge that raises SCK matches the far end's view.
                        bit_next      = bit_reg - 4'd1;
                        state_next    = SCK_HI;
                        sck_next      = 1'b1;
                        rx_shift_next = {rx_shift_reg[14:0], SPI_MISO};
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next     = '0;
                    state_next   = IDLE;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    rx_data_next = rx_shift_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rx_data  = rx_data_reg;
    assign SPI_SCK  = sck_reg;
    assign SPI_CS   = cs_reg;
    assign SPI_MOSI = mosi_reg;

endmodule

// File: tb/tb_block_spi_master.sv
// Scoreboard bench for block_spi_master: two instances (CLK_DIV/CS_GAP = 2/4 and 1/1),
// each with a stimulus process, a frame-level slave/monitor, and a shared check counter.
`timescale 1ns/1ps
module tb_block_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] frame;
        logic [15:0] rx;
        bit          loop;
        int          delay;
        int          acc;
    } item_t;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] pat;
        bit          loop;
        bit          held;
        bit          spur;
        bit          midrst;
        int          delay;
    } desc_t;

    task automatic check(input int inst, input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL u%0d %s: got 0x%0h, required 0x%0h", inst, name, act, req);
        end
    endtask

    function automatic desc_t mk(input logic [7:0] a, input logic [7:0] d, input bit lp,
                                 input bit hd, input bit sp, input bit mr, input int dl);
        desc_t r;
        r.addr   = a;
        r.data   = d;
        r.pat    = 16'($urandom);
        r.loop   = lp;
        r.held   = hd;
        r.spur   = sp;
        r.midrst = mr;
        r.delay  = dl;
        return r;
    endfunction

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 2 : 1;
        localparam int G = (gi == 0) ? 4 : 1;

        logic        rst, start, busy, done, sck, cs, mosi, miso;
        logic [7:0]  addr, data;
        logic [15:0] rx_data;
        logic        miso_bit;
        bit          loop_m;
        int          rises;
        bit          fin;
        item_t       sb[$];

        assign miso = loop_m ? mosi : miso_bit;

        block_spi_master #(.CLK_DIV(D), .CS_GAP(G)) u_dut (
            .clk        (clk),
            .reset      (rst),
            .start      (start),
            .address_in (addr),
            .data_in    (data),
            .busy       (busy),
            .done       (done),
            .rx_data    (rx_data),
            .SPI_SCK    (sck),
            .SPI_CS     (cs),
            .SPI_MOSI   (mosi),
            .SPI_MISO   (miso)
        );

        // Stimulus: issues frames, pushes the expected outcome, never looks at results.
        initial begin : stim
            desc_t plan[$];
            desc_t p;
            item_t it;
            int    w;
            rst   = 1'b1;
            start = 1'b0;
            addr  = '0;
            data  = '0;
            fin   = 1'b0;
            plan.push_back(mk(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0));
            plan.push_back(mk(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 3))));
            for (int i = 0; i < 4; i++)
                plan.push_back(mk(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 0));
            for (int i = 0; i < 4; i++)
                plan.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                                  1'b0, 1'b1, 1'b0, int'($urandom_range(0, 3))));
            if (gi == 0) begin
                plan.push_back(mk(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 0));
                plan.push_back(mk(8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1));
            end
            repeat (3) @(negedge clk);
            rst = 1'b0;
            foreach (plan[k]) begin
                p = plan[k];
                w = 0;
                while (busy && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                if (busy) check(gi, 1'b0, "busy never dropped", 32'(busy), 32'd0);
                if (p.delay > 0) begin
                    start = 1'b0;
                    repeat (p.delay) @(negedge clk);
                end
                addr     = p.addr;
                data     = p.data;
                start    = 1'b1;
                it.frame = {p.addr, p.data};
                it.rx    = p.loop ? {p.addr, p.data} : p.pat;
                it.loop  = p.loop;
                it.delay = p.delay;
                it.acc   = edge_cnt + 1;
                sb.push_back(it);
                @(negedge clk);
                check(gi, busy == 1'b1, "busy after accept", 32'(busy), 32'd1);
                if (!p.held) start = 1'b0;
                if (p.spur) begin
                    repeat ($urandom_range(2, 10)) @(negedge clk);
                    addr  = 8'($urandom);
                    data  = 8'($urandom);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                if (p.midrst) begin
                    w = 0;
                    while (rises != 8 && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    check(gi, rises == 8, "reached 8th SCK rise", 32'(rises), 32'd8);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
            start = 1'b0;
            w = 0;
            while (sb.size() != 0 && w < 500) begin
                @(negedge clk);
                w++;
            end
            check(gi, sb.size() == 0, "frames outstanding at end", 32'(sb.size()), 32'd0);
            fin = 1'b1;
        end

        // Slave model and monitor: rebuilds each frame from the SPI pins and checks timing.
        initial begin : mon
            item_t       cur;
            logic        pcs, psck, pmosi, hi_mosi;
            logic [15:0] sl, last_rx;
            int          rise_edge, fall_edge, last_chg;
            bit          have_fall;
            pcs = 0; psck = 0; pmosi = 0; hi_mosi = 0; sl = '0; last_rx = '0;
            rise_edge = 0; fall_edge = 0; last_chg = 0; have_fall = 0;
            rises = 0; miso_bit = 1'b0; loop_m = 1'b0;
            cur = '{frame: 16'h0, rx: 16'h0, loop: 1'b0, delay: 0, acc: 0};
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    check(gi, {cs, sck, mosi, busy, done} == 5'b0, "outputs in reset",
                          32'({cs, sck, mosi, busy, done}), 32'd0);
                    check(gi, rx_data == 16'h0, "rx_data in reset", 32'(rx_data), 32'd0);
                    sb.delete();
                    have_fall = 0; rises = 0; last_rx = '0;
                    pcs = 0; psck = 0; pmosi = 0;
                    loop_m = 1'b0; miso_bit = 1'b0;
                end else begin
                    if (mosi !== pmosi) last_chg = edge_cnt;
                    if (cs && !pcs) begin
                        if (sb.size() == 0) begin
                            check(gi, 1'b0, "unexpected frame", 32'({addr, data}), 32'd0);
                        end else begin
                            cur = sb[0];
                            check(gi, edge_cnt == cur.acc, "CS rise edge", 32'(edge_cnt), 32'(cur.acc));
                            if (have_fall)
                                check(gi, edge_cnt - fall_edge == G + 1 + cur.delay, "CS low between frames",
                                      32'(edge_cnt - fall_edge), 32'(G + 1 + cur.delay));
                            check(gi, rx_data == last_rx, "rx_data held", 32'(rx_data), 32'(last_rx));
                        end
                        rise_edge = edge_cnt;
                        rises     = 0;
                        sl        = '0;
                        loop_m    = cur.loop;
                        miso_bit  = cur.rx[15];
                    end
                    if (sck && !psck) begin
                        check(gi, (edge_cnt - last_chg) >= D, "MOSI setup before rise",
                              32'(edge_cnt - last_chg), 32'(D));
                        sl      = {sl[14:0], mosi};
                        hi_mosi = mosi;
                        rises++;
                        if (rises < 16) miso_bit = cur.rx[15 - rises];
                    end else if (sck && psck) begin
                        check(gi, mosi == hi_mosi, "MOSI stable while SCK high", 32'(mosi), 32'(hi_mosi));
                    end
                    if (!cs && pcs) begin
                        check(gi, edge_cnt - rise_edge == 33 * D, "CS high length",
                              32'(edge_cnt - rise_edge), 32'(33 * D));
                        check(gi, rises == 16, "SCK rises per frame", 32'(rises), 32'd16);
                        check(gi, sl == cur.frame, "slave frame", 32'(sl), 32'(cur.frame));
                        fall_edge = edge_cnt;
                    end
                    if (done) begin
                        if (sb.size() == 0) begin
                            check(gi, 1'b0, "unexpected done", 32'(done), 32'd0);
                        end else begin
                            check(gi, edge_cnt - sb[0].acc + 1 == 33 * D + G + 1, "done cycles after start cycle",
                                  32'(edge_cnt - sb[0].acc + 1), 32'(33 * D + G + 1));
                            check(gi, edge_cnt - fall_edge == G, "CS low before done",
                                  32'(edge_cnt - fall_edge), 32'(G));
                            check(gi, {busy, cs, sck} == 3'b0, "busy/cs/sck at done",
                                  32'({busy, cs, sck}), 32'd0);
                            check(gi, rx_data == sb[0].rx, "rx_data", 32'(rx_data), 32'(sb[0].rx));
                            $display("u%0d frame addr=%02h data=%02h rx_data=%04h at edge %0d",
                                     gi, sb[0].frame[15:8], sb[0].frame[7:0], rx_data, edge_cnt);
                            last_rx = sb[0].rx;
                            void'(sb.pop_front());
                            have_fall = 1;
                        end
                    end
                    pcs   = cs;
                    psck  = sck;
                    pmosi = mosi;
                end
            end
        end
    end

    initial begin : top_ctl
        int w;
        w = 0;
        while (!(g_inst[0].fin && g_inst[1].fin) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check(-1, g_inst[0].fin && g_inst[1].fin, "stimulus completed",
              32'({g_inst[1].fin, g_inst[0].fin}), 32'd3);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d edges, required completion", edge_cnt);
        $fatal(1, "time limit");
    end

endmodule
